// File: rtl/db_ram_1p_msk.sv
// db_ram_1p_msk: single-port SRAM for the deblocking-filter datapath with
// active-low per-byte write masking, optional output register, read-valid
// strobe and a clear engine that zeroes the array after reset or on request.
module db_ram_1p_msk #(
  parameter int unsigned Word_Width = 128,
  parameter int unsigned Addr_Width = 8,
  parameter int unsigned Byte_Width = 8,
  parameter int unsigned Out_Reg    = 1,
  parameter int unsigned Clr_En     = 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             clr_i,
  output logic                             busy_o,
  input  logic                             cen_i,
  input  logic                             wen_i,
  input  logic                             oen_i,
  input  logic [Word_Width/Byte_Width-1:0] bwen_i,
  input  logic [Addr_Width-1:0]            addr_i,
  input  logic [Word_Width-1:0]            data_i,
  output logic [Word_Width-1:0]            data_o,
  output logic                             val_o
);

  localparam int unsigned NB    = Word_Width / Byte_Width;
  localparam int unsigned Depth = 1 << Addr_Width;

  typedef enum logic {
    IDLE,
    CLR
  } state_t;

  state_t                state_q, state_d;
  logic [Addr_Width-1:0] cnt_q, cnt_d;
  logic [Word_Width-1:0] mem [Depth];

  logic                  busy;
  logic                  rd_req;
  logic                  wr_req;

  // First read stage: captures the array word (or zero when oen_i was high)
  logic                  s1_v_q;
  logic [Word_Width-1:0] s1_d_q;

  assign busy   = (state_q == CLR);
  assign busy_o = busy;
  assign rd_req = !busy && !cen_i &&  wen_i;
  assign wr_req = !busy && !cen_i && !wen_i;

  // Clear-engine next state: CLR sweeps cnt from 0 to all-ones, then returns
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = CLR;
          cnt_d   = '0;
        end
      end
      CLR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear-engine state; reset parks in CLR when the auto-clear is enabled so
  // the sweep begins on the first cycle after rstn is released
  always_ff @(posedge clk) begin
    if (!rstn) begin
      if (Clr_En != 0) begin
        state_q <= CLR;
      end else begin
        state_q <= IDLE;
      end
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array write port: clear sweep has priority, user writes are lane-masked
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (busy) begin
        mem[cnt_q] <= '0;
      end else if (wr_req) begin
        for (int unsigned k = 0; k < NB; k++) begin
          if (!bwen_i[k]) begin
            mem[addr_i][k*Byte_Width +: Byte_Width] <= data_i[k*Byte_Width +: Byte_Width];
          end
        end
      end
    end
  end

  // Read stage 1: data register only loads on a read so the last result holds
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_v_q <= 1'b0;
      s1_d_q <= '0;
    end else begin
      s1_v_q <= rd_req;
      if (rd_req) begin
        s1_d_q <= oen_i ? '0 : mem[addr_i];
      end
    end
  end

  if (Out_Reg != 0) begin : g_oreg
    logic                  s2_v_q;
    logic [Word_Width-1:0] s2_d_q;

    // Optional output register: adds one cycle of latency to data and strobe
    always_ff @(posedge clk) begin
      if (!rstn) begin
        s2_v_q <= 1'b0;
        s2_d_q <= '0;
      end else begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_d_q <= s1_d_q;
        end
      end
    end

    assign val_o  = s2_v_q;
    assign data_o = s2_d_q;
  end else begin : g_noreg
    assign val_o  = s1_v_q;
    assign data_o = s1_d_q;
  end

endmodule

// File: tb/tb_db_ram_1p_msk.sv
// Bench for db_ram_1p_msk: directed and random accesses checked every cycle
// against a behavioural memory model with a latency queue.
module tb_db_ram_1p_msk;

  localparam int unsigned WW      = 128;
  localparam int unsigned AW      = 8;
  localparam int unsigned BW      = 8;
  localparam int unsigned NB      = WW / BW;
  localparam int unsigned DEPTH   = 1 << AW;
  localparam int unsigned OUT_REG = 1;
  localparam int unsigned CLR_EN  = 1;
  localparam int unsigned LAT     = (OUT_REG != 0) ? 2 : 1;

  logic          clk;
  logic          rstn;
  logic          clr_i;
  logic          busy_o;
  logic          cen_i;
  logic          wen_i;
  logic          oen_i;
  logic [NB-1:0] bwen_i;
  logic [AW-1:0] addr_i;
  logic [WW-1:0] data_i;
  logic [WW-1:0] data_o;
  logic          val_o;

  db_ram_1p_msk #(
    .Word_Width(WW),
    .Addr_Width(AW),
    .Byte_Width(BW),
    .Out_Reg   (OUT_REG),
    .Clr_En    (CLR_EN)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (clr_i),
    .busy_o(busy_o),
    .cen_i (cen_i),
    .wen_i (wen_i),
    .oen_i (oen_i),
    .bwen_i(bwen_i),
    .addr_i(addr_i),
    .data_i(data_i),
    .data_o(data_o),
    .val_o (val_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WW-1:0] ref_mem [DEPTH];
  bit            pv [$];
  logic [WW-1:0] pd [$];
  logic [WW-1:0] exp_data;
  bit            exp_val;
  int            clr_left;

  function automatic void model_flush();
    pv.delete();
    pd.delete();
    for (int i = 0; i < int'(LAT) - 1; i++) begin
      pv.push_back(1'b0);
      pd.push_back('0);
    end
  endfunction

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs held across the edge, then check
  task automatic cycle();
    bit            nv;
    logic [WW-1:0] nd;
    logic [WW-1:0] tmp;
    @(posedge clk);
    nv = 1'b0;
    nd = '0;
    if (!rstn) begin
      model_flush();
      exp_data = '0;
      exp_val  = 1'b0;
      clr_left = (CLR_EN != 0) ? int'(DEPTH) : 0;
    end else begin
      if (clr_left > 0) begin
        clr_left--;
        if (clr_left == 0) begin
          for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        end
      end else begin
        if (clr_i) clr_left = int'(DEPTH);
        if (!cen_i && wen_i) begin
          nv = 1'b1;
          nd = oen_i ? '0 : ref_mem[addr_i];
        end else if (!cen_i && !wen_i) begin
          for (int k = 0; k < int'(NB); k++) begin
            if (!bwen_i[k]) ref_mem[addr_i][k*BW +: BW] = data_i[k*BW +: BW];
          end
        end
      end
      pv.push_back(nv);
      pd.push_back(nd);
      exp_val = pv.pop_front();
      tmp     = pd.pop_front();
      if (exp_val) exp_data = tmp;
    end
    #1;
    check("val_o", val_o, exp_val);
    check("data_o", data_o, exp_data);
    check("busy_o", busy_o, clr_left > 0);
  endtask

  task automatic idle(input int n);
    cen_i = 1'b1; wen_i = 1'b1; oen_i = 1'b0; clr_i = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic oe);
    cen_i = 1'b0; wen_i = 1'b1; oen_i = oe; addr_i = a; clr_i = 1'b0;
    cycle();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WW-1:0] d, input logic [NB-1:0] bw);
    cen_i = 1'b0; wen_i = 1'b0; oen_i = 1'b0; addr_i = a; data_i = d; bwen_i = bw; clr_i = 1'b0;
    cycle();
  endtask

  task automatic rand_inputs(input bit with_clr);
    cen_i  = ($urandom_range(3) == 0) ? 1'b1 : 1'b0;
    wen_i  = 1'($urandom);
    oen_i  = ($urandom_range(4) == 0) ? 1'b1 : 1'b0;
    bwen_i = NB'($urandom);
    addr_i = AW'($urandom_range(15));
    data_i = {$urandom, $urandom, $urandom, $urandom};
    clr_i  = with_clr ? 1'($urandom) : 1'b0;
  endtask

  // Count cycles until busy_o drops; garbage drives random user traffic meanwhile
  task automatic wait_clear(output int n, input bit garbage);
    n = 0;
    while (busy_o === 1'b1 && n < 2000) begin
      if (garbage) rand_inputs(1'b1);
      else begin
        cen_i = 1'b1; clr_i = 1'b0;
      end
      cycle();
      n++;
    end
    cen_i = 1'b1; clr_i = 1'b0;
  endtask

  int n;

  initial begin
    rstn = 1'b0; clr_i = 1'b0; cen_i = 1'b1; wen_i = 1'b1; oen_i = 1'b0;
    bwen_i = '1; addr_i = '0; data_i = '0;
    model_flush();
    exp_data = '0; exp_val = 1'b0; clr_left = int'(DEPTH);

    // Reset, then automatic clear
    repeat (3) cycle();
    rstn = 1'b1;
    wait_clear(n, 1'b0);
    check("busy_len_init", n, DEPTH);

    rd(8'h00, 1'b0); rd(8'h7F, 1'b0); rd(8'hFF, 1'b0);
    idle(LAT + 1);

    // Masked write: the low four lanes take the all-ones data
    wr(8'd5, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'h0000);
    wr(8'd5, '1, 16'hFFF0);
    rd(8'd5, 1'b0);
    idle(LAT);
    check("mask_word", data_o, 128'h00112233_44556677_8899AABB_FFFFFFFF);

    // Back-to-back reads in order
    wr(8'd1, {4{32'h1111_0001}}, '0);
    wr(8'd2, {4{32'h2222_0002}}, '0);
    wr(8'd3, {4{32'h3333_0003}}, '0);
    rd(8'd1, 1'b0); rd(8'd2, 1'b0); rd(8'd3, 1'b0);
    idle(LAT + 1);

    // Output enable gating
    rd(8'd5, 1'b1);
    idle(LAT);
    check("oen_zero", data_o, '0);
    rd(8'd5, 1'b0);
    idle(LAT);
    check("oen_data", data_o, 128'h00112233_44556677_8899AABB_FFFFFFFF);

    // Read-after-write on consecutive cycles
    wr(8'd9, {4{32'hDEAD_BEEF}}, 16'h00FF);
    rd(8'd9, 1'b0);
    idle(LAT + 1);

    // Fill with A5, clear on request with ignored traffic, read back zeros
    for (int a = 0; a < int'(DEPTH); a++) wr(AW'(a), {NB{8'hA5}}, '0);
    rd(8'd77, 1'b0);
    clr_i = 1'b1; cen_i = 1'b1;
    cycle();
    wait_clear(n, 1'b1);
    check("busy_len_clr", n, DEPTH);
    rd(8'h00, 1'b0); rd(8'hFF, 1'b0);
    for (int i = 0; i < 16; i++) rd(AW'($urandom), 1'b0);
    idle(LAT + 1);
    check("clr_zero", data_o, '0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rand_inputs(1'b0);
      cycle();
    end
    idle(LAT + 1);

    // Reset at clear cycle 100 restarts a full sweep
    clr_i = 1'b1; cen_i = 1'b1;
    cycle();
    idle(100);
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    wait_clear(n, 1'b0);
    check("busy_len_rst", n, DEPTH);

    // A read in flight at reset is discarded
    wr(8'd4, {4{32'hCAFE_F00D}}, '0);
    rd(8'd4, 1'b0);
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    wait_clear(n, 1'b0);
    check("busy_len_rst2", n, DEPTH);
    rd(8'd4, 1'b0);
    idle(LAT + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
